// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: funct3 size codes, FSM encoding, default memory size.
package lsu_pkg;

  localparam int LSU_MEM_BYTES = 64;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_RD = 3'd1;
  localparam logic [2:0] S_ST_RD   = 3'd2;
  localparam logic [2:0] S_ST_WR   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

endpackage

// File: rtl/lsu_data_align.sv
// Combinational load extraction and store merge. The requested bytes always sit in the low bytes
// of the memory word, so no shifting is needed.
module lsu_data_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_ext,
  output logic [XLEN-1:0] store_merged
);

  always_comb begin
    load_ext = '0;
    case (funct3)
      F3_B:    load_ext = {{(XLEN-8){rdata[7]}}, rdata[7:0]};
      F3_H:    load_ext = {{(XLEN-16){rdata[15]}}, rdata[15:0]};
      F3_W:    load_ext = {{(XLEN-32){rdata[31]}}, rdata[31:0]};
      F3_D:    load_ext = rdata;
      F3_BU:   load_ext = {{(XLEN-8){1'b0}}, rdata[7:0]};
      F3_HU:   load_ext = {{(XLEN-16){1'b0}}, rdata[15:0]};
      F3_WU:   load_ext = {{(XLEN-32){1'b0}}, rdata[31:0]};
      default: load_ext = '0;
    endcase
  end

  // Upper bytes keep the old memory contents; only the stored width is replaced.
  always_comb begin
    store_merged = rdata;
    case (funct3[1:0])
      2'b00:   store_merged[7:0]  = wdata[7:0];
      2'b01:   store_merged[15:0] = wdata[15:0];
      2'b10:   store_merged[31:0] = wdata[31:0];
      default: store_merged       = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request at a time, read-modify-write for sub-doubleword stores,
// extended load data returned over a valid/ready response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = LSU_MEM_BYTES,
  parameter int XLEN      = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_err,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_read,
  output logic            mem_write,
  input  logic [XLEN-1:0] mem_rdata
);

  logic [2:0]      state;
  logic [XLEN-1:0] addr_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] resp_data_q;
  logic            resp_err_q;
  logic [XLEN-1:0] load_ext;
  logic [XLEN-1:0] store_merged;
  logic            illegal;

  lsu_data_align #(.XLEN(XLEN)) u_align (
    .funct3       (funct3_q),
    .rdata        (mem_rdata),
    .wdata        (wdata_q),
    .load_ext     (load_ext),
    .store_merged (store_merged)
  );

  assign illegal = (!req_store && req_funct3 == 3'b111)
                 || (req_store && req_funct3[2])
                 || (req_addr > XLEN'(MEM_BYTES - 8));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      funct3_q    <= '0;
      wdata_q     <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          addr_q      <= req_addr;
          funct3_q    <= req_funct3;
          wdata_q     <= req_wdata;
          resp_data_q <= '0;
          resp_err_q  <= illegal;
          if (illegal)                 state <= S_DONE;
          else if (!req_store)         state <= S_LOAD_RD;
          else if (req_funct3 == F3_D) state <= S_ST_WR;
          else                         state <= S_ST_RD;
        end
        S_LOAD_RD: begin
          resp_data_q <= load_ext;
          state       <= S_DONE;
        end
        // wdata_q is reused to hold the merged word for the following write cycle.
        S_ST_RD: begin
          wdata_q <= store_merged;
          state   <= S_ST_WR;
        end
        S_ST_WR: state <= S_DONE;
        S_DONE:  if (resp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_DONE);
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_read   = (state == S_LOAD_RD) || (state == S_ST_RD);
  assign mem_write  = (state == S_ST_WR) && !reset;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: byte-array memory model, scoreboard queue of expected responses.
module tb_load_store_unit;

  typedef struct {
    logic [63:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_store, resp_valid, resp_ready, resp_err;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_wdata, resp_data, mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  logic [7:0]  mem [0:63];
  logic        init_done = 1'b0;
  exp_t        exp_q [$];
  int          n_assert = 0;
  int          n_fail   = 0;

  load_store_unit #(.MEM_BYTES(64), .XLEN(64)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] preload(input int i);
    if (i == 0)                 return 8'h03;
    if (i == 8)                 return 8'h05;
    if (i >= 16 && i < 24)      return 8'hA0 + 8'(i - 16);
    if (i >= 24 && i < 32)      return 8'(i - 23);
    if (i == 40)                return 8'h80;
    return 8'h00;
  endfunction

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 64; i++) mem[i] <= preload(i);
      init_done <= 1'b1;
    end else if (mem_write) begin
      for (int i = 0; i < 8; i++) begin
        logic [63:0] a;
        a = mem_addr + 64'(i);
        if (a < 64) mem[a[5:0]] <= mem_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    mem_rdata = '0;
    if (mem_read)
      for (int i = 0; i < 8; i++) begin
        logic [63:0] a;
        a = mem_addr + 64'(i);
        if (a < 64) mem_rdata[8*i +: 8] = mem[a[5:0]];
      end
  end

  function automatic logic [63:0] rd64(input int base);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = mem[base + i];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a request and return after the edge that accepts it.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, input logic [63:0] ed, input logic ee);
    int w;
    exp_t e;
    e.data = ed; e.err = ee;
    exp_q.push_back(e);
    @(negedge clk);
    req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    chk("accept_timeout", 64'(w < 20), 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input int lat, input int nrd, input int nwr,
                         input logic [63:0] ewd);
    int cyc, rd, wr;
    logic [63:0] wd_seen;
    exp_t e;
    cyc = 0; rd = 0; wr = 0; wd_seen = '0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (mem_read) rd++;
      if (mem_write) begin wr++; wd_seen = mem_wdata; end
      if (resp_valid) break;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(lat));
    chk({tag, "_reads"}, 64'(rd), 64'(nrd));
    chk({tag, "_writes"}, 64'(wr), 64'(nwr));
    if (nwr > 0) chk({tag, "_wdata"}, wd_seen, ewd);
    if (exp_q.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, resp_data, e.data);
      chk({tag, "_err"}, 64'(resp_err), 64'(e.err));
    end
  endtask

  task automatic release_resp(input string tag);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_ready"}, 64'(req_ready), 64'd1);
    chk({tag, "_idle_novalid"}, 64'(resp_valid), 64'd0);
  endtask

  task automatic txn(input string tag, input logic st, input logic [2:0] f3,
                     input logic [63:0] a, input logic [63:0] wd, input logic [63:0] ed,
                     input logic ee, input int lat, input int nrd, input int nwr,
                     input logic [63:0] ewd);
    issue(st, f3, a, wd, ed, ee);
    collect(tag, lat, nrd, nwr, ewd);
    release_resp(tag);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_mem_read", 64'(mem_read), 64'd0);
    chk("rst_mem_write", 64'(mem_write), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    reset = 1'b0;

    // loads and stores: tag, store, funct3, addr, wdata, exp data, exp err, latency, reads, writes, exp wdata
    txn("ld8",   1'b0, 3'b011, 64'd8,  64'd0, 64'd5, 1'b0, 2, 1, 0, 64'd0);
    txn("sb0",   1'b1, 3'b000, 64'd0,  64'hFFFF_FFFF_FFFF_FFAB, 64'd0, 1'b0, 3, 1, 1, 64'h0000_0000_0000_00AB);
    txn("ld0",   1'b0, 3'b011, 64'd0,  64'd0, 64'h0000_0000_0000_00AB, 1'b0, 2, 1, 0, 64'd0);
    txn("lb40",  1'b0, 3'b000, 64'd40, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 2, 1, 0, 64'd0);
    txn("lbu40", 1'b0, 3'b100, 64'd40, 64'd0, 64'h0000_0000_0000_0080, 1'b0, 2, 1, 0, 64'd0);
    txn("lh40",  1'b0, 3'b001, 64'd40, 64'd0, 64'h0000_0000_0000_0080, 1'b0, 2, 1, 0, 64'd0);
    txn("ld57",  1'b0, 3'b011, 64'd57, 64'd0, 64'd0, 1'b1, 1, 0, 0, 64'd0);
    txn("st100", 1'b1, 3'b100, 64'd0,  64'hFF, 64'd0, 1'b1, 1, 0, 0, 64'd0);
    txn("ld111", 1'b0, 3'b111, 64'd0,  64'd0, 64'd0, 1'b1, 1, 0, 0, 64'd0);
    txn("ld56",  1'b0, 3'b011, 64'd56, 64'd0, 64'd0, 1'b0, 2, 1, 0, 64'd0);
    txn("sw24",  1'b1, 3'b010, 64'd24, 64'hDEAD_BEEF_CAFE_F00D, 64'd0, 1'b0, 3, 1, 1, 64'h0807_0605_CAFE_F00D);
    txn("lw24",  1'b0, 3'b010, 64'd24, 64'd0, 64'hFFFF_FFFF_CAFE_F00D, 1'b0, 2, 1, 0, 64'd0);
    txn("lwu24", 1'b0, 3'b110, 64'd24, 64'd0, 64'h0000_0000_CAFE_F00D, 1'b0, 2, 1, 0, 64'd0);
    txn("lhu26", 1'b0, 3'b101, 64'd26, 64'd0, 64'h0000_0000_0000_CAFE, 1'b0, 2, 1, 0, 64'd0);
    txn("lh26",  1'b0, 3'b001, 64'd26, 64'd0, 64'hFFFF_FFFF_FFFF_CAFE, 1'b0, 2, 1, 0, 64'd0);
    txn("sh33",  1'b1, 3'b001, 64'd33, 64'h1234, 64'd0, 1'b0, 3, 1, 1, 64'h8000_0000_0000_1234);
    txn("sd48",  1'b1, 3'b011, 64'd48, 64'h0123_4567_89AB_CDEF, 64'd0, 1'b0, 2, 0, 1, 64'h0123_4567_89AB_CDEF);
    txn("ld48",  1'b0, 3'b011, 64'd48, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b0, 2, 1, 0, 64'd0);

    // Back-pressure in DONE with a competing request held on the input.
    issue(1'b0, 3'b011, 64'd8, 64'd0, 64'd5, 1'b0);
    collect("stall", 2, 1, 0, 64'd0);
    req_store = 1'b0; req_funct3 = 3'b100; req_addr = 64'd40; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", 64'(resp_valid), 64'd1);
      chk("stall_data", resp_data, 64'd5);
      chk("stall_err", 64'(resp_err), 64'd0);
      chk("stall_req_ready", 64'(req_ready), 64'd0);
    end
    begin
      exp_t e;
      e.data = 64'h80; e.err = 1'b0;
      exp_q.push_back(e);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    chk("stall_idle_ready", 64'(req_ready), 64'd1);
    chk("stall_idle_novalid", 64'(resp_valid), 64'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("stall_next_accepted", 64'(req_ready), 64'd0);
    collect("stall_next", 2, 1, 0, 64'd0);
    release_resp("stall_next");

    // Reset landing in the write cycle of an sd must suppress the write and the response.
    @(negedge clk);
    req_store = 1'b1; req_funct3 = 3'b011; req_addr = 64'd16;
    req_wdata = 64'h1122_3344_5566_7788; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1 chk("rst_wr_no_write", 64'(mem_write), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_wr_req_ready", 64'(req_ready), 64'd1);
    chk("rst_wr_mem_kept", rd64(16), 64'hA7A6_A5A4_A3A2_A1A0);
    for (int i = 0; i < 3; i++) begin
      chk("rst_wr_no_resp", 64'(resp_valid), 64'd0);
      @(negedge clk);
    end
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface. Sits between the execute stage and the byte-addressed, 64-bit-wide data memory.
- Accepts one load/store request at a time over a valid/ready handshake and drives the memory's address, write-data, read-enable and write-enable lines.
- Sub-doubleword stores are done as read-modify-write, because the memory always writes 8 bytes.
- Loads are extracted and sign- or zero-extended to 64 bits, and the result is returned over a valid/ready response handshake.

Parameters:
- MEM_BYTES, 64, data-memory size in bytes. A legal access needs addr <= MEM_BYTES-8.
- XLEN, 64, data and address width.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request.
- req_store  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3 size/sign code.
- req_addr  input  XLEN  byte address.
- req_wdata  input  XLEN  store data, right-aligned.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts the response.
- resp_data  output  XLEN  extended load data; 0 for stores.
- resp_err  output  1  illegal funct3 or out-of-range address.
- mem_addr  output  XLEN  to memory address.
- mem_wdata  output  XLEN  to memory write data.
- mem_read  output  1  memory read enable.
- mem_write  output  1  memory write enable, sampled by memory at posedge clk.
- mem_rdata  input  XLEN  memory read data, combinational from mem_addr while mem_read=1.

Behaviour:
- Memory model: little-endian. The 8-byte window starting at mem_addr appears on mem_rdata, so the requested bytes are always the low bytes. No alignment restriction.
- FSM states: IDLE, LOAD_RD, ST_RD, ST_WR, DONE.
- Reset: state=IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_err=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0. Registered latches cleared.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr, funct3, store, wdata.
  - If the request is illegal -> DONE with err=1. No memory access is made.
  - Otherwise: load -> LOAD_RD; store with funct3=011 -> ST_WR; other legal store -> ST_RD.
- Illegal requests:
  - Load funct3=111.
  - Store funct3>=100.
  - Any request with addr > MEM_BYTES-8.
- LOAD_RD:
  - mem_read=1, mem_addr=latched addr.
  - At the posedge, register the extracted value and go to DONE.
  - Extraction: 000 sext byte; 001 sext half; 010 sext word; 011 full; 100/101/110 zero-extend byte/half/word.
- ST_RD:
  - mem_read=1.
  - At the posedge, register the merged word: the low 1/2/4 bytes come from wdata, the upper bytes from mem_rdata.
  - Go to ST_WR.
- ST_WR:
  - mem_write=1, mem_wdata = merged word (sd: wdata unchanged).
  - Next state DONE.
- DONE:
  - resp_valid=1; resp_data and resp_err held stable.
  - On resp_ready go to IDLE in the next cycle.
  - No new request is accepted in DONE (req_ready=0).
- Outside the active states, mem_read/mem_write are 0; they are a function of state only.
- mem_write is additionally gated by !reset, so a reset asserted in ST_WR causes no write.
- Latency from the accepting edge to resp_valid: load 2 cycles, sd 2, sb/sh/sw 3, error 1.
- Throughput: at most one request every latency+1 cycles. The IDLE cycle after DONE is mandatory.
- Reset mid-operation: abandon the transaction with no response; IDLE in the next cycle.
- resp_data is 0 for stores and for errors.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU.
  - State encoding localparams.
  - MEM_BYTES default.
- One sub-module, lsu_data_align (combinational):
  - Inputs: funct3, rdata, wdata.
  - Outputs: load_ext, store_merged.
  - Instantiated once; the top holds the FSM and registers.

Test Plan:
1. Memory bytes 8..15 = 5,0,...,0; ld addr 8 -> resp_valid two cycles after accept, resp_data=5, resp_err=0, mem_write never 1.
2. Memory dword at 0 = 0x0000_0000_0000_0003; sb wdata=0x...AB addr 0 -> mem_read 1 cycle, then mem_write 1 cycle with mem_wdata=0x0000_0000_0000_00AB; a following ld addr 0 returns 0xAB.
3. Byte 40 = 0x80; lb addr 40 -> 0xFFFF_FFFF_FFFF_FF80; lbu addr 40 -> 0x0000_0000_0000_0080; lh addr 40 -> 0x0000_0000_0000_0080 (byte 41 = 0).
4. ld addr 57 (MEM_BYTES=64), and separately a store with funct3=100 -> resp_err=1 one cycle after accept, resp_data=0, mem_read=mem_write=0 throughout.
5. resp_ready held 0 for 3 cycles in DONE -> resp_valid, resp_data, resp_err stable; req_ready=0 with req_valid=1 present; a request is accepted only after the handshake and the IDLE cycle.
6. sd 0x1122_3344_5566_7788 addr 16 with reset asserted in the ST_WR cycle -> mem_write=0 that cycle, bytes 16..23 unchanged, no resp_valid; req_ready=1 the following cycle.
